// File: rtl/c2hdl_seq_pkg.sv
// Shared types and default timing constants for the c2hdl call sequencer.
package c2hdl_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_POST,
    S_DONE
  } seq_state_t;

  localparam int unsigned DEF_PCW       = 10;
  localparam int unsigned DEF_SETUP_CYC = 3;
  localparam int unsigned DEF_POST_CYC  = 3;
  localparam int unsigned DEF_MIN_RUN   = 1;
  localparam int unsigned DEF_TIMEOUT   = 65535;

endpackage

// File: rtl/c2hdl_call_sequencer.sv
// Issues N back-to-back setb/idle call handshakes to a c2hdl-generated core
// for each command accepted over valid/ready.
module c2hdl_call_sequencer
  import c2hdl_seq_pkg::*;
#(
  parameter int unsigned PCW       = DEF_PCW,
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned POST_CYC  = DEF_POST_CYC,
  parameter int unsigned MIN_RUN   = DEF_MIN_RUN,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [PCW-1:0] cmd_pc,
  input  logic [PCW-1:0] cmd_ra,
  input  logic [31:0]    cmd_sp,
  input  logic [31:0]    cmd_a0,
  input  logic [31:0]    cmd_a0_step,
  input  logic [15:0]    cmd_count,
  input  logic           abort,
  output logic           core_setb,
  input  logic           core_idle,
  output logic [PCW-1:0] core_pc0,
  output logic [PCW-1:0] core_ra0,
  output logic [31:0]    core_sp0,
  output logic [31:0]    core_a00,
  output logic           busy,
  output logic           done,
  output logic           err_timeout,
  output logic [15:0]    calls_done,
  output logic [31:0]    last_cycles
);

  seq_state_t     r_state, w_nextState;
  logic [15:0]    r_count, r_callsDone, w_callsNext;
  logic [31:0]    r_step, r_phaseCnt, r_runCnt, r_lastCycles, r_sp0, r_a00;
  logic [PCW-1:0] r_pc0, r_ra0;
  logic           r_setb, r_busy, r_done, r_errTimeout;
  logic           w_accept, w_phaseEnd, w_idleSeen, w_timeoutHit;
  logic           w_callEnd, w_lastCall;

  // Idle wins over a timeout on the same cycle; abort wins over everything.
  always_comb begin
    w_nextState  = r_state;
    w_accept     = 1'b0;
    w_phaseEnd   = 1'b0;
    w_idleSeen   = 1'b0;
    w_timeoutHit = 1'b0;
    w_callEnd    = 1'b0;
    w_callsNext  = r_callsDone + 16'd1;
    w_lastCall   = (w_callsNext == r_count);
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_nextState = (cmd_count == 16'd0) ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: begin
        w_phaseEnd = (r_phaseCnt == SETUP_CYC - 1);
        if (abort)           w_nextState = S_DONE;
        else if (w_phaseEnd) w_nextState = S_RUN;
      end
      S_RUN: begin
        w_idleSeen   = core_idle && (r_runCnt > MIN_RUN);
        w_timeoutHit = (TIMEOUT != 32'd0) && (r_runCnt == TIMEOUT) && !w_idleSeen;
        if (abort || w_timeoutHit) w_nextState = S_DONE;
        else if (w_idleSeen)       w_nextState = S_POST;
      end
      S_POST: begin
        w_phaseEnd = (r_phaseCnt == POST_CYC - 1);
        if (abort) begin
          w_nextState = S_DONE;
        end else if (w_phaseEnd) begin
          w_callEnd   = 1'b1;
          w_nextState = w_lastCall ? S_DONE : S_SETUP;
        end
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // setb and done are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_setb       <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_errTimeout <= 1'b0;
      r_phaseCnt   <= '0;
      r_runCnt     <= 32'd1;
      r_count      <= '0;
      r_step       <= '0;
      r_callsDone  <= '0;
      r_lastCycles <= '0;
      r_pc0        <= '0;
      r_ra0        <= '0;
      r_sp0        <= '0;
      r_a00        <= '0;
    end else begin
      r_setb     <= (w_nextState == S_RUN) || (w_nextState == S_POST);
      r_done     <= (w_nextState == S_DONE);
      r_phaseCnt <= (w_nextState != r_state) ? 32'd0 : r_phaseCnt + 32'd1;
      if (r_state != S_RUN)     r_runCnt <= 32'd1;
      else if (r_runCnt != '1)  r_runCnt <= r_runCnt + 32'd1;
      if (w_accept) begin
        r_count      <= cmd_count;
        r_step       <= cmd_a0_step;
        r_pc0        <= cmd_pc;
        r_ra0        <= cmd_ra;
        r_sp0        <= cmd_sp;
        r_a00        <= cmd_a0;
        r_callsDone  <= '0;
        r_errTimeout <= 1'b0;
        r_busy       <= 1'b1;
      end else if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end
      if (w_timeoutHit)         r_errTimeout <= 1'b1;
      if (w_idleSeen && !abort) r_lastCycles <= r_runCnt;
      if (w_callEnd) begin
        r_callsDone <= w_callsNext;
        if (!w_lastCall) r_a00 <= r_a00 + r_step;
      end
    end
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign core_setb   = r_setb;
  assign core_pc0    = r_pc0;
  assign core_ra0    = r_ra0;
  assign core_sp0    = r_sp0;
  assign core_a00    = r_a00;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_timeout = r_errTimeout;
  assign calls_done  = r_callsDone;
  assign last_cycles = r_lastCycles;

endmodule

// File: tb/tb_c2hdl_call_sequencer.sv
// Bench for c2hdl_call_sequencer: a behavioural core plus a per-command
// reference computed from call delays, checked through checkOutput.
module tb_c2hdl_call_sequencer;

  localparam int PCW    = 10;
  localparam int SETUP  = 3;
  localparam int POST   = 3;
  localparam int MINRUN = 5;
  localparam int TOUT   = 100;

  logic           clk = 1'b0;
  logic           rstb = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [PCW-1:0] cmd_pc = '0, cmd_ra = '0;
  logic [31:0]    cmd_sp = '0, cmd_a0 = '0, cmd_a0_step = '0;
  logic [15:0]    cmd_count = '0;
  logic           abort = 1'b0;
  logic           core_setb, coreIdle;
  logic [PCW-1:0] core_pc0, core_ra0;
  logic [31:0]    core_sp0, core_a00;
  logic           busy, done, err_timeout;
  logic [15:0]    calls_done;
  logic [31:0]    last_cycles;

  always #5 clk = ~clk;

  c2hdl_call_sequencer #(
    .PCW(PCW), .SETUP_CYC(SETUP), .POST_CYC(POST), .MIN_RUN(MINRUN), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rstb(rstb),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pc(cmd_pc), .cmd_ra(cmd_ra), .cmd_sp(cmd_sp), .cmd_a0(cmd_a0),
    .cmd_a0_step(cmd_a0_step), .cmd_count(cmd_count), .abort(abort),
    .core_setb(core_setb), .core_idle(coreIdle),
    .core_pc0(core_pc0), .core_ra0(core_ra0), .core_sp0(core_sp0), .core_a00(core_a00),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .calls_done(calls_done), .last_cycles(last_cycles)
  );

  int nCompared = 0;
  int nMismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Core model: idle rises on the d-th consecutive setb-high cycle of call i
  // (d = dlyArr[i], 0 = never); tbHold forces idle high all the time.
  int   dlyArr [128];
  bit   tbHold = 1'b0;
  int   fallCnt = 0, fallBase = 0, highCnt = 0, curDelay;
  logic prevSetb = 1'b0;

  always @(posedge clk) begin
    highCnt <= core_setb ? highCnt + 1 : 0;
    if (!core_setb && prevSetb) fallCnt <= fallCnt + 1;
    prevSetb <= core_setb;
  end

  always_comb begin
    curDelay = dlyArr[(fallCnt - fallBase) & 127];
    coreIdle = tbHold || (core_setb && curDelay != 0 && (highCnt + 1) >= curDelay);
  end

  int expLast = 0;

  function automatic int effRun(input int d, input bit hold);
    if (hold)       return MINRUN + 1;
    if (d == 0)     return TOUT + 1;
    if (d > MINRUN) return d;
    return MINRUN + 1;
  endfunction

  task automatic applyStimulus(input int cnt, input logic [31:0] a0, input logic [31:0] step,
                               input logic [31:0] sp, input logic [PCW-1:0] pc,
                               input logic [PCW-1:0] ra, input bit hold,
                               input int abortCall, input int abortCyc);
    int lim, nDone, expLat, expRises, runLen, lat, busyCnt, rises, highRun, lowRun, gapErr, a00Err;
    bit expErr, timedOut, seen, abortPend;
    logic prevS;
    logic [31:0] expA00;
    nDone = 0; expErr = 0; timedOut = 0; expLat = 2; expRises = 0;
    lim = (abortCall != 0) ? abortCall - 1 : cnt;
    for (int i = 0; i < lim; i++) begin
      expRises++;
      runLen = effRun(dlyArr[i], hold);
      if (runLen > TOUT) begin
        expErr = 1; timedOut = 1; expLat += SETUP + TOUT;
        break;
      end
      expLat += SETUP + runLen + POST;
      nDone++;
      expLast = runLen;
    end
    if (abortCall != 0 && !timedOut) expRises++;
    expA00 = a0 + step * 32'((expRises > 0) ? expRises - 1 : 0);

    @(negedge clk);
    checkOutput("cmdReady", cmd_ready, 1);
    cmd_pc = pc; cmd_ra = ra; cmd_sp = sp; cmd_a0 = a0; cmd_a0_step = step;
    cmd_count = 16'(cnt); tbHold = hold; fallBase = fallCnt; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;

    lat = 1; busyCnt = 0; rises = 0; highRun = 0; lowRun = 0; gapErr = 0; a00Err = 0;
    seen = 0; abortPend = 0; prevS = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (abortPend) begin
        abort = 1'b0; abortPend = 0;
        checkOutput("abortSetbLow", core_setb, 0);
      end
      if (busy) busyCnt++;
      if (core_setb && !prevS) begin
        rises++;
        if (lowRun < SETUP) gapErr++;
        if (core_a00 !== a0 + step * 32'(rises - 1)) a00Err++;
        highRun = 0;
      end
      if (core_setb) begin highRun++; lowRun = 0; end
      else lowRun++;
      prevS = core_setb;
      if (abortCall != 0 && core_setb && rises == abortCall && highRun == abortCyc) begin
        abort = 1'b1; abortPend = 1;
      end
      if (done) seen = 1;
    end
    checkOutput("doneSeen", seen, 1);
    if (abortCall == 0) checkOutput("latency", lat, expLat);
    checkOutput("busyCycles", busyCnt, lat - 1);
    checkOutput("callsDone", calls_done, nDone);
    checkOutput("errTimeout", err_timeout, expErr);
    checkOutput("setbPulses", rises, expRises);
    checkOutput("lastCycles", last_cycles, expLast);
    checkOutput("finalA00", core_a00, expA00);
    checkOutput("sp0", core_sp0, sp);
    checkOutput("pc0", core_pc0, pc);
    checkOutput("ra0", core_ra0, ra);
    checkOutput("setupGap", gapErr, 0);
    checkOutput("a00PerCall", a00Err, 0);
    @(negedge clk);
    checkOutput("donePulseEnd", {done, busy, core_setb}, 3'b000);
    checkOutput("readyAgain", cmd_ready, 1);
  endtask

  initial begin
    int rises, runCyc, doneCnt, r;
    logic prevS;
    $display("[TB] start");
    for (int i = 0; i < 128; i++) dlyArr[i] = 20;
    repeat (3) @(negedge clk);
    checkOutput("rstSetb", core_setb, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstErr", err_timeout, 0);
    checkOutput("rstCalls", calls_done, 0);
    checkOutput("rstLast", last_cycles, 0);
    checkOutput("rstCore", {core_pc0, core_ra0, core_sp0, core_a00}, 0);
    rstb = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterRst", cmd_ready, 1);

    applyStimulus(1, 32'h1000, 32'h0, 32'h1ffc, 10'h000, 10'h044, 0, 0, 0);
    applyStimulus(75, 32'h1000, 32'h4, 32'h1ffc, 10'h000, 10'h044, 0, 0, 0);
    applyStimulus(0, 32'h55, 32'h1, 32'h77, 10'h3, 10'h4, 0, 0, 0);
    for (int i = 0; i < 128; i++) dlyArr[i] = 0;
    applyStimulus(2, 32'h10, 32'h1, 32'h20, 10'h1, 10'h2, 0, 0, 0);
    for (int i = 0; i < 128; i++) dlyArr[i] = 10;
    applyStimulus(1, 32'h10, 32'h1, 32'h20, 10'h1, 10'h2, 0, 0, 0);
    applyStimulus(3, 32'h400, 32'h8, 32'h900, 10'h11, 10'h22, 1, 0, 0);
    dlyArr[0] = 100; dlyArr[1] = 6; dlyArr[2] = 101;
    applyStimulus(3, 32'h0, 32'h3, 32'h0, 10'h5, 10'h6, 0, 0, 0);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 128; i++) begin
        r = $urandom_range(0, 9);
        case (r)
          0:       dlyArr[i] = 0;
          1:       dlyArr[i] = 100;
          2:       dlyArr[i] = 101;
          3:       dlyArr[i] = $urandom_range(1, 6);
          default: dlyArr[i] = $urandom_range(1, 40);
        endcase
      end
      applyStimulus($urandom_range(0, 6), $urandom, $urandom, $urandom, 10'($urandom),
                    10'($urandom), ($urandom_range(0, 7) == 0), 0, 0);
    end

    for (int i = 0; i < 128; i++) dlyArr[i] = 50;
    applyStimulus(10, 32'h2000, 32'h10, 32'h3000, 10'h10, 10'h80, 0, 3, 5);

    // Drop reset in the middle of the third call's RUN phase.
    @(negedge clk);
    cmd_count = 16'd10; tbHold = 1'b0; fallBase = fallCnt; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    rises = 0; runCyc = 0; prevS = 1'b0;
    for (int c = 0; c < 5000 && runCyc < 8; c++) begin
      @(negedge clk);
      if (core_setb && !prevS) rises++;
      prevS = core_setb;
      if (rises == 3 && core_setb) runCyc++;
    end
    checkOutput("reachRun3", runCyc, 8);
    checkOutput("callsBeforeRst", calls_done, 2);
    #2 rstb = 1'b0;
    #1;
    checkOutput("asyncSetb", core_setb, 0);
    checkOutput("asyncBusy", busy, 0);
    checkOutput("asyncCalls", calls_done, 0);
    checkOutput("asyncLast", last_cycles, 0);
    doneCnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    rstb = 1'b1;
    expLast = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("noDoneAfterRst", doneCnt, 0);
    for (int i = 0; i < 128; i++) dlyArr[i] = 12;
    applyStimulus(2, 32'h7, 32'h1, 32'h8, 10'h9, 10'ha, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/c2hdl_call_sequencer.md
Name: c2hdl_call_sequencer

Overview:
- Initiator for the function-call handshake of a c2hdl-generated core (pc0/ra0/sp0/a00 entry values, setb start, idle completion).
- Accepts a call command over valid/ready, then drives N back-to-back calls: set up entry registers, release setb, wait for idle, drop setb.
- Sits between a host/controller and any compiled core (e.g. quicksort), so benches and SoC glue no longer hand-sequence calls.

Parameters:
- PCW, 10, width of core_pc0/core_ra0 and cmd_pc/cmd_ra.
- SETUP_CYC, 3, cycles with setb=0 and entry values stable before setb rises (>=1).
- POST_CYC, 3, cycles setb stays 1 after idle is seen (>=1).
- MIN_RUN, 1, cycles after setb rises during which idle is ignored (>=1).
- TIMEOUT, 65535, maximum RUN cycles per call before abort; 0 disables.

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_pc  in  PCW  function entry address
- cmd_ra  in  PCW  return address (core goes idle on return)
- cmd_sp  in  32  initial stack pointer
- cmd_a0  in  32  first-call a0 argument
- cmd_a0_step  in  32  added to a0 after each call (wraps mod 2^32)
- cmd_count  in  16  number of calls
- abort  in  1  synchronous abort request
- core_setb  out  1  core run enable (0 = load entry state)
- core_idle  in  1  core finished
- core_pc0  out  PCW  entry pc
- core_ra0  out  PCW  entry ra
- core_sp0  out  32  entry sp
- core_a00  out  32  entry a0
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes or aborts
- err_timeout  out  1  sticky; set on timeout, cleared on next accepted command
- calls_done  out  16  calls completed in current/last command
- last_cycles  out  32  RUN cycles of the most recent completed call (saturating)

Behaviour:
- Reset (async, rstb=0): state S_IDLE; core_setb=0; all core_* outputs=0; busy=0; done=0; err_timeout=0; calls_done=0; last_cycles=0; cmd_ready=1 after reset release.
- States: S_IDLE, S_SETUP, S_RUN, S_POST, S_DONE.
- S_IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register all cmd_* fields, load core_pc0/ra0/sp0/a00, clear calls_done and err_timeout, and set busy=1. If cmd_count=0, go to S_DONE; otherwise go to S_SETUP. cmd_ready=0 in every other state.
- S_SETUP: core_setb=0; count SETUP_CYC cycles, then go to S_RUN.
- S_RUN: core_setb=1; run counter starts at 1 on the first RUN cycle.
  - core_idle is ignored while the counter <= MIN_RUN.
  - After that, core_idle=1 captures last_cycles=counter and goes to S_POST.
  - If TIMEOUT!=0 and counter==TIMEOUT without idle: set err_timeout, core_setb=0 next cycle, go to S_DONE; calls_done is not incremented.
- S_POST: core_setb=1 for POST_CYC cycles, then core_setb=0 and calls_done+=1.
  - If calls_done(new)==count, go to S_DONE.
  - Otherwise core_a00+=a0_step and go to S_SETUP. core_pc0/ra0/sp0 are unchanged between calls.
- S_DONE: done=1 for exactly one cycle, busy=0, go to S_IDLE. Core outputs hold their last values.
- abort=1 in S_SETUP/S_RUN/S_POST: next cycle core_setb=0, go to S_DONE; calls_done is not incremented for the interrupted call. abort in S_IDLE/S_DONE is ignored. If abort and timeout hit in the same cycle, err_timeout is still set.
- core_setb never toggles 0->1 without >=SETUP_CYC prior cycles at 0 with stable entry values.
- Mid-operation async reset: all outputs return to reset values immediately; no done pulse.
- last_cycles saturates at 2^32-1.
- Latency of a single call = 1 (accept) + SETUP_CYC + run cycles + POST_CYC + 1 (done).

Decomposition:
- Shared package c2hdl_seq_pkg: state enum (S_IDLE..S_DONE) and default SETUP_CYC/POST_CYC/TIMEOUT constants.
- No sub-module needed; the counters stay inline. An optional generic down-counter is not warranted.

Test Plan:
- Core model that goes idle 20 cycles after setb rises; cmd pc=0x000, ra=0x044, sp=0x1ffc, a0=0x1000, step=0, count=1 -> one setb pulse with 3 low cycles before it, last_cycles=20, calls_done=1, single done pulse, core_sp0=0x1ffc.
- Same model, count=75, step=4, a0=0x1000 -> 75 setb pulses, core_a00 on the final call=0x1000+74*4=0x1128, calls_done=75, done pulses exactly once.
- count=0 -> no setb activity, done pulses 2 cycles after accept, busy high 1 cycle, calls_done=0.
- Model never asserts idle, TIMEOUT=100 -> setb low after RUN cycle 100, err_timeout=1, calls_done=0, done pulse; the next accepted command clears err_timeout.
- Model holds idle=1 continuously, MIN_RUN=5 -> idle honoured only from RUN cycle 6, last_cycles=6.
- abort in the 3rd call's RUN (count=10) -> setb=0 next cycle, calls_done=2, done pulse. Repeat with rstb dropped mid-RUN -> core_setb=0 and busy=0 asynchronously, no done pulse.
